// File: rtl/approx_mon_pkg.sv
// approx_mon_pkg: shared FSM state type and width constants for the approximate-multiplier error monitor
package approx_mon_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    localparam int OPW_DEFAULT = 16;
    localparam int DRAIN_CYCLES = 2;
    localparam int PW_DEFAULT = 2 * OPW_DEFAULT;
    localparam int EDW_DEFAULT = PW_DEFAULT;
    localparam int SUMW_DEFAULT = PW_DEFAULT + 16;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
endpackage

// File: rtl/ed_calc.sv
// ed_calc: exact unsigned product and absolute error distance against an approximate product
module ed_calc
    import approx_mon_pkg::*;
#(
    parameter int OPW = OPW_DEFAULT
) (
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   x,
    input  logic [2*OPW-1:0] approx,
    output logic [2*OPW-1:0] exact,
    output logic [2*OPW-1:0] ed
);
    always_comb begin
        exact = {{OPW{1'b0}}, a} * {{OPW{1'b0}}, x};
        ed = (exact >= approx) ? exact - approx : approx - exact;
    end
endmodule

// File: rtl/approx_error_monitor.sv
// approx_error_monitor: run-based ED statistics over a 2-stage pipeline with IDLE/RUN/DRAIN/DONE control
module approx_error_monitor
    import approx_mon_pkg::*;
#(
    parameter int OPW = OPW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         sample_target,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPW-1:0]      in_a,
    input  logic [OPW-1:0]      in_x,
    input  logic [2*OPW-1:0]    in_product,
    output logic                busy,
    output logic                done,
    output logic [15:0]         samples_done,
    output logic [15:0]         err_count,
    output logic [2*OPW+15:0]   ed_sum,
    output logic [2*OPW-1:0]    ed_max
);
    localparam int PW = 2 * OPW;
    localparam int SW = PW + 16;
    state_e state_q, state_d;
    logic [15:0] target_q, target_d, samples_q, samples_d, err_q, err_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s2_err_q, s2_err_d;
    logic [OPW-1:0] s1_a_q, s1_a_d, s1_x_q, s1_x_d;
    logic [PW-1:0] s1_p_q, s1_p_d, s2_ed_q, s2_ed_d, max_q, max_d, exact, ed;
    logic [SW-1:0] sum_q, sum_d;
    logic accept, start_ok;

    ed_calc #(.OPW(OPW)) u_ed_calc (
        .a(s1_a_q),
        .x(s1_x_q),
        .approx(s1_p_q),
        .exact(exact),
        .ed(ed)
    );

    assign in_ready = (state_q == RUN) && (samples_q < target_q);
    assign busy = (state_q == RUN) || (state_q == DRAIN);
    assign done = state_q == DONE;
    assign samples_done = samples_q;
    assign err_count = err_q;
    assign ed_sum = sum_q;
    assign ed_max = max_q;

    always_comb begin
        accept = in_valid && in_ready;
        start_ok = start && ((state_q == IDLE) || (state_q == DONE));
        state_d = state_q;
        target_d = target_q;
        drain_d = drain_q;
        samples_d = samples_q;
        err_d = err_q;
        sum_d = sum_q;
        max_d = max_q;
        s1_valid_d = accept;
        s1_a_d = accept ? in_a : s1_a_q;
        s1_x_d = accept ? in_x : s1_x_q;
        s1_p_d = accept ? in_product : s1_p_q;
        s2_valid_d = s1_valid_q;
        s2_ed_d = ed;
        s2_err_d = exact != s1_p_q;
        if (s2_valid_q) begin
            sum_d = sum_q + {16'b0, s2_ed_q};
            max_d = (s2_ed_q > max_q) ? s2_ed_q : max_q;
            err_d = err_q + {15'b0, s2_err_q};
        end
        if (start_ok) begin
            state_d = (sample_target != 16'd0) ? RUN : DONE;
            target_d = sample_target;
            samples_d = '0;
            err_d = '0;
            sum_d = '0;
            max_d = '0;
        end
        if (accept) begin
            samples_d = samples_q + 16'd1;
            if (samples_q + 16'd1 == target_q) begin
                state_d = DRAIN;
                drain_d = '0;
            end
        end
        if (state_q == DRAIN) begin
            drain_d = drain_q + 1'b1;
            state_d = (drain_q == DRAIN_LAST) ? DONE : DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            target_q <= '0;
            drain_q <= '0;
            samples_q <= '0;
            err_q <= '0;
            sum_q <= '0;
            max_q <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q <= '0;
            s1_x_q <= '0;
            s1_p_q <= '0;
            s2_valid_q <= 1'b0;
            s2_ed_q <= '0;
            s2_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            target_q <= target_d;
            drain_q <= drain_d;
            samples_q <= samples_d;
            err_q <= err_d;
            sum_q <= sum_d;
            max_q <= max_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q <= s1_a_d;
            s1_x_q <= s1_x_d;
            s1_p_q <= s1_p_d;
            s2_valid_q <= s2_valid_d;
            s2_ed_q <= s2_ed_d;
            s2_err_q <= s2_err_d;
        end
    end
endmodule
